// File: rtl/local_history_predicate_predictor_pkg.sv
// Shared constants and helpers for the local-history predicate predictor.
// Default sizes match the control-path configuration of the predicate unit.
package local_history_predicate_predictor_pkg;

  localparam int TIA_NUM_PREDICATES           = 8;
  localparam int TIA_DI_WIDTH                 = 3;
  localparam int TIA_PREDICTOR_HISTORY_LENGTH = 2;
  localparam int TIA_PREDICTOR_COUNTER_WIDTH  = 2;
  localparam int TIA_PREDICTOR_TABLE_DEPTH    = 2 ** TIA_PREDICTOR_HISTORY_LENGTH;
  localparam int TIA_PREDICTOR_WEAKLY_FALSE   = 2 ** (TIA_PREDICTOR_COUNTER_WIDTH - 1) - 1;

  typedef enum logic [1:0] {
    STAT_IDLE,
    STAT_HIT,
    STAT_MISS,
    STAT_CONFLICT
  } stat_event_e;

  // Weakly-false is the largest counter value whose MSB is still clear.
  function automatic int weakly_false(input int width);
    return 2 ** (width - 1) - 1;
  endfunction

  function automatic stat_event_e classify_stat(input logic hit, input logic miss);
    case ({hit, miss})
      2'b10:   return STAT_HIT;
      2'b01:   return STAT_MISS;
      2'b11:   return STAT_CONFLICT;
      default: return STAT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/local_history_predicate_predictor_saturating_counter.sv
// Up/down counter that clamps at zero and at all-ones instead of wrapping.
// Simultaneous increment and decrement cancel out.
module saturating_counter #(
  parameter int               WIDTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             increment,
  input  logic             decrement,
  input  logic             clear,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] MAX_VALUE = '1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= RESET_VALUE;
    end else if (enable) begin
      if (clear) begin
        value <= RESET_VALUE;
      end else if (increment && !decrement) begin
        if (value != MAX_VALUE) value <= value + WIDTH'(1);
      end else if (decrement && !increment) begin
        if (value != '0) value <= value - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/local_history_predicate_predictor.sv
// Two-level local-history predictor: each predicate's outcome history picks a
// saturating counter in its own pattern table; also tracks hit/miss statistics.
module local_history_predicate_predictor
  import local_history_predicate_predictor_pkg::*;
#(
  parameter int NUM_PREDICATES = TIA_NUM_PREDICATES,
  parameter int DI_WIDTH       = TIA_DI_WIDTH,
  parameter int HISTORY_LENGTH = TIA_PREDICTOR_HISTORY_LENGTH,
  parameter int COUNTER_WIDTH  = TIA_PREDICTOR_COUNTER_WIDTH,
  parameter int STAT_WIDTH     = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      datapath_write,
  input  logic [DI_WIDTH-1:0]       datapath_di,
  input  logic                      observed_value,
  input  logic                      prediction_hit,
  input  logic                      prediction_miss,
  input  logic                      clear_statistics,
  output logic [NUM_PREDICATES-1:0] predictions,
  output logic [STAT_WIDTH-1:0]     hit_count,
  output logic [STAT_WIDTH-1:0]     miss_count,
  output logic                      protocol_error
);

  localparam int TABLE_DEPTH = 2 ** HISTORY_LENGTH;
  localparam logic [COUNTER_WIDTH-1:0] WEAKLY_FALSE =
    COUNTER_WIDTH'(weakly_false(COUNTER_WIDTH));

  logic [HISTORY_LENGTH-1:0] hist [NUM_PREDICATES];
  logic [COUNTER_WIDTH-1:0]  pht  [NUM_PREDICATES][TABLE_DEPTH];
  logic [NUM_PREDICATES-1:0] write_sel;
  logic [DI_WIDTH:0]         di_ext;
  stat_event_e               stat_event;

  // Out-of-range indices match no predicate, so such writes fall through silently.
  assign di_ext = {1'b0, datapath_di};

  always_comb begin
    write_sel = '0;
    for (int p = 0; p < NUM_PREDICATES; p++) begin
      write_sel[p] = enable && datapath_write && (di_ext == (DI_WIDTH + 1)'(p));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PREDICATES; p++) hist[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PREDICATES; p++) begin
        if (write_sel[p]) hist[p] <= (hist[p] << 1) | HISTORY_LENGTH'(observed_value);
      end
    end
  end

  for (genvar p = 0; p < NUM_PREDICATES; p++) begin : g_pred
    for (genvar e = 0; e < TABLE_DEPTH; e++) begin : g_entry
      logic entry_write;
      assign entry_write = write_sel[p] && (hist[p] == HISTORY_LENGTH'(e));

      saturating_counter #(
        .WIDTH      (COUNTER_WIDTH),
        .RESET_VALUE(WEAKLY_FALSE)
      ) u_counter (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .increment(entry_write && observed_value),
        .decrement(entry_write && !observed_value),
        .clear    (1'b0),
        .value    (pht[p][e])
      );
    end
  end

  // Read from registered state only; an update becomes visible after its edge.
  always_comb begin
    predictions = '0;
    for (int p = 0; p < NUM_PREDICATES; p++) begin
      predictions[p] = pht[p][hist[p]][COUNTER_WIDTH-1];
    end
  end

  assign stat_event = classify_stat(prediction_hit, prediction_miss);

  saturating_counter #(
    .WIDTH      (STAT_WIDTH),
    .RESET_VALUE('0)
  ) u_hit_counter (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .increment(stat_event == STAT_HIT),
    .decrement(1'b0),
    .clear    (clear_statistics),
    .value    (hit_count)
  );

  saturating_counter #(
    .WIDTH      (STAT_WIDTH),
    .RESET_VALUE('0)
  ) u_miss_counter (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .increment(stat_event == STAT_MISS),
    .decrement(1'b0),
    .clear    (clear_statistics),
    .value    (miss_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      protocol_error <= 1'b0;
    end else if (enable) begin
      if (clear_statistics) protocol_error <= 1'b0;
      else if (stat_event == STAT_CONFLICT) protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_local_history_predicate_predictor.sv
// Scoreboard bench for the local-history predicate predictor; a 4-bit index
// reaches out-of-range predicates and a 3-bit-stat copy exposes saturation.
module tb_local_history_predicate_predictor;

  localparam int NP      = 8;
  localparam int DIW     = 4;
  localparam int SMALL_W = 3;
  localparam longint BIG_MAX   = 64'hFFFF_FFFF;
  localparam int     SMALL_MAX = 7;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic datapath_write = 1'b0;
  logic [DIW-1:0] datapath_di = '0;
  logic observed_value = 1'b0;
  logic prediction_hit = 1'b0;
  logic prediction_miss = 1'b0;
  logic clear_statistics = 1'b0;

  logic [NP-1:0]      predictions, small_predictions;
  logic [31:0]        hit_count, miss_count;
  logic [SMALL_W-1:0] small_hit_count, small_miss_count;
  logic               protocol_error, small_protocol_error;

  always #5 clock = ~clock;

  local_history_predicate_predictor #(
    .NUM_PREDICATES(NP), .DI_WIDTH(DIW), .HISTORY_LENGTH(2),
    .COUNTER_WIDTH(2), .STAT_WIDTH(32)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .datapath_write(datapath_write), .datapath_di(datapath_di),
    .observed_value(observed_value), .prediction_hit(prediction_hit),
    .prediction_miss(prediction_miss), .clear_statistics(clear_statistics),
    .predictions(predictions), .hit_count(hit_count), .miss_count(miss_count),
    .protocol_error(protocol_error)
  );

  local_history_predicate_predictor #(
    .NUM_PREDICATES(NP), .DI_WIDTH(DIW), .HISTORY_LENGTH(2),
    .COUNTER_WIDTH(2), .STAT_WIDTH(SMALL_W)
  ) small_dut (
    .clock(clock), .reset(reset), .enable(enable),
    .datapath_write(datapath_write), .datapath_di(datapath_di),
    .observed_value(observed_value), .prediction_hit(prediction_hit),
    .prediction_miss(prediction_miss), .clear_statistics(clear_statistics),
    .predictions(small_predictions), .hit_count(small_hit_count),
    .miss_count(small_miss_count), .protocol_error(small_protocol_error)
  );

  // Reference model: recent outcomes as an integer, counters as plain integers.
  int     m_hist [NP];
  int     m_ctr  [NP][4];
  longint m_hit, m_miss;
  int     m_small_hit, m_small_miss;
  bit     m_err;

  typedef struct packed {
    logic [NP-1:0]           pred;
    logic [NP-1:0][1:0]      hist;
    logic [NP-1:0][3:0][1:0] ctr;
    logic [31:0]             hit;
    logic [31:0]             miss;
    logic [SMALL_W-1:0]      small_hit;
    logic [SMALL_W-1:0]      small_miss;
    logic                    err;
  } expect_t;

  expect_t sb [$];
  int checks = 0;
  int errors = 0;

  task automatic check_value(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [NP-1:0] model_pred();
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) r[p] = (m_ctr[p][m_hist[p]] >= 2);
    return r;
  endfunction

  function automatic expect_t snapshot();
    expect_t s;
    s.pred = model_pred();
    for (int p = 0; p < NP; p++) begin
      s.hist[p] = 2'(m_hist[p]);
      for (int e = 0; e < 4; e++) s.ctr[p][e] = 2'(m_ctr[p][e]);
    end
    s.hit        = 32'(m_hit);
    s.miss       = 32'(m_miss);
    s.small_hit  = SMALL_W'(m_small_hit);
    s.small_miss = SMALL_W'(m_small_miss);
    s.err        = m_err;
    return s;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_hist[p] = 0;
      for (int e = 0; e < 4; e++) m_ctr[p][e] = 1;
    end
    m_hit = 0; m_miss = 0; m_small_hit = 0; m_small_miss = 0; m_err = 0;
  endtask

  task automatic model_update(input bit en, input bit wr, input int di, input bit obs,
                              input bit hit, input bit miss, input bit clr);
    if (!en) return;
    if (wr && di < NP) begin
      if (obs) m_ctr[di][m_hist[di]] = (m_ctr[di][m_hist[di]] == 3) ? 3 : m_ctr[di][m_hist[di]] + 1;
      else     m_ctr[di][m_hist[di]] = (m_ctr[di][m_hist[di]] == 0) ? 0 : m_ctr[di][m_hist[di]] - 1;
      m_hist[di] = (m_hist[di] * 2 + (obs ? 1 : 0)) % 4;
    end
    if (clr) begin
      m_hit = 0; m_miss = 0; m_small_hit = 0; m_small_miss = 0; m_err = 0;
    end else if (hit && miss) begin
      m_err = 1;
    end else if (hit) begin
      if (m_hit < BIG_MAX) m_hit++;
      if (m_small_hit < SMALL_MAX) m_small_hit++;
    end else if (miss) begin
      if (m_miss < BIG_MAX) m_miss++;
      if (m_small_miss < SMALL_MAX) m_small_miss++;
    end
  endtask

  // Drives one cycle, confirms outputs still reflect pre-edge state, queues the post-edge state.
  task automatic apply_stimulus(input bit en, input bit wr, input int di, input bit obs,
                                input bit hit, input bit miss, input bit clr, input bit rst);
    @(negedge clock);
    enable = en; datapath_write = wr; datapath_di = DIW'(di);
    observed_value = obs; prediction_hit = hit; prediction_miss = miss;
    clear_statistics = clr; reset = !rst;
    if (rst) model_reset();
    #1;
    check_value("comb_predictions", 64'(predictions), 64'(model_pred()));
    if (!rst) model_update(en, wr, di, obs, hit, miss, clr);
    sb.push_back(snapshot());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic after_edge();
    @(posedge clock);
    #3;
  endtask

  task automatic check_output(input expect_t e);
    logic [NP-1:0][1:0]      act_hist;
    logic [NP-1:0][3:0][1:0] act_ctr;
    for (int p = 0; p < NP; p++) begin
      act_hist[p] = dut.hist[p];
      for (int e2 = 0; e2 < 4; e2++) act_ctr[p][e2] = dut.pht[p][e2];
    end
    check_value("predictions", 64'(predictions), 64'(e.pred));
    check_value("histories", 64'(act_hist), 64'(e.hist));
    check_value("pattern_tables", 64'(act_ctr), 64'(e.ctr));
    check_value("hit_count", 64'(hit_count), 64'(e.hit));
    check_value("miss_count", 64'(miss_count), 64'(e.miss));
    check_value("protocol_error", 64'(protocol_error), 64'(e.err));
    check_value("small_hit_count", 64'(small_hit_count), 64'(e.small_hit));
    check_value("small_miss_count", 64'(small_miss_count), 64'(e.small_miss));
  endtask

  // Monitor: every edge, retire the oldest expectation against the DUT.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (sb.size() > 0) check_output(sb.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    after_edge();
    check_value("reset_predictions", 64'(predictions), 64'h0);
    check_value("reset_pht_3_3", 64'(dut.pht[3][3]), 64'h1);

    // di=3 learns a steady stream of ones.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1, 1, 3, 1, 0, 0, 0, 0);
      after_edge();
      if (i < 2) check_value("di3_early_pred", 64'(predictions[3]), 64'h0);
    end
    check_value("di3_learned_pred", 64'(predictions[3]), 64'h1);
    check_value("di3_saturated_ctr", 64'(dut.pht[3][3]), 64'h3);

    // di=5 alternation becomes predictable once both patterns are trained.
    for (int i = 0; i < 16; i++) begin
      if (i >= 4) check_value("di5_alternation", 64'(predictions[5]), 64'((i % 2) == 0));
      apply_stimulus(1, 1, 5, (i % 2) == 0, 0, 0, 0, 0);
      after_edge();
    end

    apply_stimulus(1, 1, 9, 1, 0, 0, 0, 0);
    apply_stimulus(1, 1, 15, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 3, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 5, 1, 1, 0, 1, 0);
    apply_stimulus(1, 1, 2, 0, 0, 0, 0, 0);

    // Statistics and sticky conflict flag.
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, 0, 1, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0, 0);
    after_edge();
    check_value("stats_hit3", 64'(hit_count), 64'd3);
    check_value("stats_miss1", 64'(miss_count), 64'd1);
    apply_stimulus(1, 0, 0, 0, 1, 1, 0, 0);
    after_edge();
    check_value("conflict_flag", 64'(protocol_error), 64'h1);
    check_value("conflict_hits_held", 64'(hit_count), 64'd3);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0);
    after_edge();
    check_value("clear_all", 64'({hit_count, miss_count, 31'h0, protocol_error}), 64'h0);
    for (int i = 0; i < 9; i++) apply_stimulus(1, 0, 0, 0, 1, 0, 0, 0);
    after_edge();
    check_value("small_hit_saturated", 64'(small_hit_count), 64'd7);

    // Third one-write to di=0 flips its prediction, with a hit on the same edge.
    apply_stimulus(1, 1, 0, 1, 0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 1, 0, 0, 0, 0);
    after_edge();
    check_value("di0_before_update", 64'(predictions[0]), 64'h0);
    apply_stimulus(1, 1, 0, 1, 1, 0, 0, 0);
    check_value("di0_same_cycle_old", 64'(predictions[0]), 64'h0);
    after_edge();
    check_value("di0_next_cycle_new", 64'(predictions[0]), 64'h1);
    check_value("di0_concurrent_hit", 64'(hit_count), 64'd10);

    // Reset in the middle of an update discards it.
    apply_stimulus(1, 1, 3, 0, 1, 0, 0, 1);
    apply_stimulus(1, 1, 3, 0, 1, 0, 0, 1);
    idle(1);
    after_edge();
    check_value("midreset_predictions", 64'(predictions), 64'h0);
    check_value("midreset_hits", 64'(hit_count), 64'h0);

    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                     int'($urandom_range(0, 11)), $urandom_range(0, 2) != 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
    end
    idle(1);

    repeat (3) @(posedge clock);
    #3;
    check_value("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
